dual_port_memory_responder: RTL and testbench

//  Memory-side responder for the CPU's two memory buses. Port 1 is a read-only instruction port
//  (address in, data out). Port 2 is a read/write data port (address in, write enable in, shared

---
 rtl/dual_port_memory_responder.sv | 151 +++++++++++++++
 tb/tb_dual_port_memory_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_memory_responder.sv
// ---------------------------------------------------------------------------
// dual_port_memory_responder
//
// Memory-side responder for the CPU's instruction and data buses. Both ports
// share one word array of DEPTH = 2**ADDR_WIDTH 32-bit words. After reset the
// array is cleared to INIT_VALUE (one word per cycle), then mem_ready rises.
//
// Ports
//   clk        in     1   clock, rising edge
//   reset      in     1   synchronous, active-low reset
//   mem_addr1  in     32  port-1 byte address (instruction fetch)
//   mem_data1  out    32  port-1 read data, registered (INIT_VALUE on error)
//   mem_err1   out    1   previous port-1 access misaligned / out of range
//   mem_we2    in     1   port-2 write enable (1 = CPU drives mem_data2)
//   mem_addr2  in     32  port-2 byte address
//   mem_data2  inout  32  port-2 data bus, driven here only for read data
//   mem_err2   out    1   previous port-2 access misaligned / out of range
//   mem_ready  out    1   high once the array has been cleared
// ---------------------------------------------------------------------------
module dual_port_memory_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr1,
    output logic [31:0] mem_data1,
    output logic        mem_err1,
    input  logic        mem_we2,
    input  logic [31:0] mem_addr2,
    inout  wire  [31:0] mem_data2,
    output logic        mem_err2,
    output logic        mem_ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   init_ptr;

    logic [31:0]             mem [DEPTH];

    logic [31:0]             off1;
    logic [31:0]             off2;
    logic                    ok1;
    logic                    ok2;
    logic [ADDR_WIDTH-1:0]   idx1;
    logic [ADDR_WIDTH-1:0]   idx2;

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_idx;
    logic [31:0]             wr_data;
    logic [31:0]             rd1_word;

    logic                    rd2_valid;
    logic [31:0]             rd2_data;

    // Address decode. The addr >= BASE_ADDR term stops an address below the
    // base from wrapping around into the valid window after subtraction.
    assign off1 = mem_addr1 - BASE_ADDR;
    assign off2 = mem_addr2 - BASE_ADDR;
    assign ok1  = (mem_addr1[1:0] == 2'b00) && (mem_addr1 >= BASE_ADDR) &&
                  ((off1 >> 2) < 32'(DEPTH));
    assign ok2  = (mem_addr2[1:0] == 2'b00) && (mem_addr2 >= BASE_ADDR) &&
                  ((off2 >> 2) < 32'(DEPTH));
    assign idx1 = off1[ADDR_WIDTH+1:2];
    assign idx2 = off2[ADDR_WIDTH+1:2];

    // Next state and the single array write port. INIT and port-2 writes
    // share the port; they cannot collide because writes only happen in RUN.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_idx     = init_ptr;
        wr_data    = INIT_VALUE;
        if (state == ST_INIT) begin
            wr_en = 1'b1;
            if (init_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                state_next = ST_RUN;
            end
        end else begin
            if (mem_we2 && ok2) begin
                wr_en   = 1'b1;
                wr_idx  = idx2;
                wr_data = mem_data2;
            end
        end
    end

    // Write-first forwarding: a port-1 read of the word being written by
    // port 2 on the same edge returns the new data.
    always_comb begin
        rd1_word = mem[idx1];
        if (wr_en && (wr_idx == idx1)) begin
            rd1_word = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_INIT;
            init_ptr  <= '0;
            mem_data1 <= INIT_VALUE;
            mem_err1  <= 1'b0;
            mem_err2  <= 1'b0;
            rd2_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                init_ptr  <= init_ptr + 1'b1;
                mem_data1 <= INIT_VALUE;
                mem_err1  <= 1'b0;
                mem_err2  <= 1'b0;
                rd2_valid <= 1'b0;
            end else begin
                mem_data1 <= ok1 ? rd1_word : INIT_VALUE;
                mem_err1  <= !ok1;
                mem_err2  <= !ok2;
                rd2_valid <= !mem_we2;
            end
        end
    end

    // Array storage; gated by reset so a write presented during a reset edge
    // is dropped (INIT would overwrite it anyway).
    always_ff @(posedge clk) begin
        if (wr_en && reset) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Port-2 read data; qualified by rd2_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == ST_RUN && !mem_we2) begin
            rd2_data <= ok2 ? mem[idx2] : 32'h0;
        end
    end

    assign mem_ready = (state == ST_RUN);

    // Bus is released combinationally the moment the CPU raises mem_we2.
    assign mem_data2 = (rd2_valid && !mem_we2) ? rd2_data : 'z;

endmodule

// File: tb/tb_dual_port_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_dual_port_memory_responder
//
// Self-checking bench: a word-array reference model with arithmetic address
// decode, directed scenarios and randomized traffic. Two instances: one with
// BASE_ADDR = 0 and one with BASE_ADDR = 0x10.
// ---------------------------------------------------------------------------
module tb_dual_port_memory_responder;

    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] INITV = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] addr1;
    logic [31:0] data1;
    logic        err1;
    logic        we2;
    logic [31:0] addr2;
    wire  [31:0] bus2;
    logic        err2;
    logic        ready;
    logic        drv_en;
    logic [31:0] drv_val;
    assign bus2 = drv_en ? drv_val : 'z;

    logic [31:0] addr1_b;
    logic [31:0] data1_b;
    logic        err1_b;
    logic        we2_b;
    logic [31:0] addr2_b;
    wire  [31:0] bus2_b;
    logic        err2_b;
    logic        ready_b;
    logic        drv_en_b;
    logic [31:0] drv_val_b;
    assign bus2_b = drv_en_b ? drv_val_b : 'z;

    dual_port_memory_responder #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (32'h0000_0000),
        .INIT_VALUE (INITV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr1 (addr1),
        .mem_data1 (data1),
        .mem_err1  (err1),
        .mem_we2   (we2),
        .mem_addr2 (addr2),
        .mem_data2 (bus2),
        .mem_err2  (err2),
        .mem_ready (ready)
    );

    dual_port_memory_responder #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (32'h0000_0010),
        .INIT_VALUE (INITV)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .mem_addr1 (addr1_b),
        .mem_data1 (data1_b),
        .mem_err1  (err1_b),
        .mem_we2   (we2_b),
        .mem_addr2 (addr2_b),
        .mem_data2 (bus2_b),
        .mem_err2  (err2_b),
        .mem_ready (ready_b)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] model [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference decode: plain arithmetic on wide integers.
    function automatic bit addr_ok(input logic [31:0] a, input longint base);
        longint off;
        off = longint'(a) - base;
        return (a % 4 == 0) && (off >= 0) && (off / 4 < DEPTH);
    endfunction

    function automatic int addr_idx(input logic [31:0] a, input longint base);
        return int'((longint'(a) - base) / 4);
    endfunction

    task automatic idle();
        addr1 = 32'h0; we2 = 1'b0; addr2 = 32'h0; drv_en = 1'b0; drv_val = 32'h0;
    endtask

    // Counts edges from reset release to mem_ready while hammering the ports
    // with random traffic that must be ignored.
    task automatic wait_init(input string tag);
        int n;
        n = 0;
        do begin
            addr1   = $urandom_range(0, 15) * 4;
            we2     = 1'($urandom_range(0, 1));
            drv_en  = we2;
            drv_val = $urandom;
            addr2   = $urandom_range(0, 15) * 4;
            @(posedge clk); #1;
            n++;
            check({tag, "_d1"}, data1, INITV);
            check({tag, "_e1"}, {31'b0, err1}, 32'h0);
            check({tag, "_e2"}, {31'b0, err2}, 32'h0);
        end while (!ready && n < 64);
        check({tag, "_len"}, n, 16);
        idle();
        for (int i = 0; i < DEPTH; i++) model[i] = INITV;
    endtask

    // One RUN cycle on the base-0 instance, checked against the model.
    task automatic cycle(input logic [31:0] a1, input bit w, input logic [31:0] a2,
                         input logic [31:0] d);
        bit          ok1;
        bit          ok2;
        logic [31:0] e1;
        logic [31:0] erd;
        addr1 = a1; we2 = w; addr2 = a2; drv_en = w; drv_val = d;
        ok1 = addr_ok(a1, 0);
        ok2 = addr_ok(a2, 0);
        erd = (!w && ok2) ? model[addr_idx(a2, 0)] : 32'h0;
        if (w && ok2) model[addr_idx(a2, 0)] = d;
        e1 = ok1 ? model[addr_idx(a1, 0)] : INITV;
        @(posedge clk); #1;
        check("rdy", {31'b0, ready}, 32'h1);
        check("d1", data1, e1);
        check("e1", {31'b0, err1}, {31'b0, !ok1});
        check("e2", {31'b0, err2}, {31'b0, !ok2});
        check(w ? "bus_wr" : "bus_rd", bus2, w ? d : erd);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) cycle(i * 4, 1'b0, i * 4, 32'h0);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return $urandom_range(0, 15) * 4;
        else if (r == 7) return $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
        else if (r == 8) return $urandom_range(16, 31) * 4;
        else             return $urandom;
    endfunction

    initial begin
        reset = 1'b0;
        idle();
        addr1_b = 32'h10; we2_b = 1'b0; addr2_b = 32'h10; drv_en_b = 1'b0; drv_val_b = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", {31'b0, ready}, 32'h0);
        check("rst_d1", data1, INITV);
        check("rst_e1", {31'b0, err1}, 32'h0);
        check("rst_e2", {31'b0, err2}, 32'h0);

        reset = 1'b1;
        wait_init("init");
        read_all();

        // Port-2 write then read back, then bus release on we2
        cycle(32'h0, 1'b1, 32'h08, 32'hDEAD_BEEF);
        cycle(32'h0, 1'b0, 32'h08, 32'h0);
        check("bus_hold", bus2, 32'hDEAD_BEEF);
        we2 = 1'b1; drv_en = 1'b1; drv_val = 32'h0;
        #1;
        check("bus_release", bus2, 32'h0);

        // Write-first collision
        cycle(32'h10, 1'b1, 32'h10, 32'h1234_5678);
        check("coll_d1", data1, 32'h1234_5678);

        // Misaligned fetch, out-of-range write, flags not sticky
        cycle(32'h06, 1'b1, 32'h40, 32'hBAD0_BAD0);
        cycle(32'h00, 1'b0, 32'h00, 32'h0);
        read_all();

        // BASE_ADDR = 0x10 instance
        we2_b = 1'b1; drv_en_b = 1'b1; drv_val_b = 32'hCAFE_F00D;
        addr2_b = 32'h10; addr1_b = 32'h0C;
        @(posedge clk); #1;
        check("b_e1_below", {31'b0, err1_b}, 32'h1);
        check("b_d1_below", data1_b, INITV);
        check("b_e2_wr", {31'b0, err2_b}, 32'h0);
        we2_b = 1'b0; drv_en_b = 1'b0; addr1_b = 32'h10; addr2_b = 32'h0C;
        @(posedge clk); #1;
        check("b_d1_w0", data1_b, 32'hCAFE_F00D);
        check("b_e1_w0", {31'b0, err1_b}, 32'h0);
        check("b_e2_below", {31'b0, err2_b}, 32'h1);
        check("b_bus_err", bus2_b, 32'h0);
        addr1_b = 32'h4C; addr2_b = 32'h10;
        @(posedge clk); #1;
        check("b_d1_top", data1_b, INITV);
        check("b_e1_top", {31'b0, err1_b}, 32'h0);
        check("b_bus_w0", bus2_b, 32'hCAFE_F00D);
        addr1_b = 32'h50;
        @(posedge clk); #1;
        check("b_e1_above", {31'b0, err1_b}, 32'h1);
        addr1_b = 32'h10;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(pick_addr(), bit'($urandom_range(0, 1)), pick_addr(), $urandom);
        end

        // Reset in RUN after writes, then reset again at INIT cycle 7
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_rdy", {31'b0, ready}, 32'h0);
        reset = 1'b1;
        wait_init("reinit");
        read_all();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
